// File: rtl/video_timing_gen.sv
// Video timing generator: horizontal/vertical counters decoded into
// registered sync, blanking and line/frame start pulses. Every output is
// registered from the same counter state, so all outputs stay mutually
// aligned one cycle behind the counters.
// Optional feature: define VTG_COORD_EN to add the pix_x/pix_y visible
// coordinate outputs; without it those ports and their logic are absent.
module video_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input  logic          vga_clk,
  input  logic          reset_n,
  input  logic          en,
  output logic          HS,
  output logic          VS,
  output logic          blank_n,
  output logic          line_start,
  output logic          frame_start
`ifdef VTG_COORD_EN
  ,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  // Totals must fit in the counters; a too-narrow CW stops elaboration.
  if (H_TOTAL >= (1 << CW)) begin : g_h_total_too_wide
    $error("video_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL >= (1 << CW)) begin : g_v_total_too_wide
    $error("video_timing_gen: V_TOTAL does not fit in CW bits");
  end

  // Region boundaries, pre-sized to the counter width.
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_E = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_E = CW'(V_SYNC);
  localparam logic [CW-1:0] H_VIS_LO = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] H_VIS_HI = CW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CW-1:0] V_VIS_LO = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] V_VIS_HI = CW'(V_SYNC + V_BACK + V_ACTIVE);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;

  logic hs_d;
  logic vs_d;
  logic vis_d;
  logic line_d;
  logic frame_d;

  // Raster position: h_cnt walks each line, v_cnt steps when a line wraps.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    // NOTE: all clocked state uses non-blocking assignments so every
    // register samples pre-edge values and simulation matches hardware.
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Decode the current counter state into next-cycle output values.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch
    // is inferred.
    hs_d    = ~HS_POL;
    vs_d    = ~VS_POL;
    vis_d   = 1'b0;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (h_cnt < H_SYNC_E) hs_d = HS_POL;
    if (v_cnt < V_SYNC_E) vs_d = VS_POL;
    if ((h_cnt >= H_VIS_LO) && (h_cnt < H_VIS_HI) &&
        (v_cnt >= V_VIS_LO) && (v_cnt < V_VIS_HI)) begin
      vis_d = 1'b1;
    end
    if (h_cnt == '0) begin
      line_d  = 1'b1;
      frame_d = (v_cnt == '0);
    end
  end

  // Output registers: load on enabled cycles; while frozen, levels hold
  // and the start pulses drop so they never repeat.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      blank_n     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      HS          <= hs_d;
      VS          <= vs_d;
      blank_n     <= vis_d;
      line_start  <= line_d;
      frame_start <= frame_d;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VTG_COORD_EN
  // Visible-area coordinates, zero during blanking, aligned with blank_n.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_x <= '0;
      pix_y <= '0;
    end else if (en) begin
      pix_x <= vis_d ? (h_cnt - H_VIS_LO) : '0;
      pix_y <= vis_d ? (v_cnt - V_VIS_LO) : '0;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a scaled-down raster:
// 17 clocks per line (sync 4, back 3, active 8, front 2) and 11 lines per
// frame (sync 2, back 3, active 4, front 2), i.e. 187 clocks per frame.
module tb_video_timing_gen;

  localparam int HSY = 4, HBK = 3, HAC = 8, HFR = 2;
  localparam int VSY = 2, VBK = 3, VAC = 4, VFR = 2;
  localparam int H_TOT = HSY + HBK + HAC + HFR;   // 17
  localparam int V_TOT = VSY + VBK + VAC + VFR;   // 11
  localparam int FRAME = H_TOT * V_TOT;           // 187
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic hs, vs, blank_n, line_start, frame_start;
`ifdef VTG_COORD_EN
  logic [CW-1:0] pix_x, pix_y;
`endif

  int n_cmp = 0;
  int n_err = 0;

  video_timing_gen #(
    .H_SYNC(HSY), .H_BACK(HBK), .H_ACTIVE(HAC), .H_FRONT(HFR),
    .V_SYNC(VSY), .V_BACK(VBK), .V_ACTIVE(VAC), .V_FRONT(VFR),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
  ) dut (
    .vga_clk    (clk),
    .reset_n    (rst_n),
    .en         (en),
    .HS         (hs),
    .VS         (vs),
    .blank_n    (blank_n),
    .line_start (line_start),
    .frame_start(frame_start)
`ifdef VTG_COORD_EN
    ,
    .pix_x      (pix_x),
    .pix_y      (pix_y)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock, then settle past the edge before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Enabled cycles until the next line_start, capped at 500.
  task automatic wait_ls(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!line_start && n < 500);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < 2000);
  endtask

  int n;
  int ls_cnt, hs_cnt, vs_cnt, bl_cnt, rises, bad_off, vs_edges, vs_bad;
  int pos, line_idx, first_line, run_hs, max_hs, run_bl, max_bl;
  int changes;
  logic prev_hs, prev_vs, prev_bl, found;
  logic [4:0] snap;
`ifdef VTG_COORD_EN
  int last_px, last_py;
`endif

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    #23;
    // Reset values with active-low syncs.
    check("rst_hs", hs, 1);
    check("rst_vs", vs, 1);
    check("rst_blank", blank_n, 0);
    check("rst_line_start", line_start, 0);
    check("rst_frame_start", frame_start, 0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // First edge decodes h_cnt=0, v_cnt=0.
    check("first_frame_start", frame_start, 1);
    check("first_line_start", line_start, 1);
    check("first_hs_active", hs, 0);
    check("first_vs_active", vs, 0);
    check("first_blank", blank_n, 0);

    // Walk one full frame window and gather raster statistics.
    ls_cnt = 0; hs_cnt = 0; vs_cnt = 0; bl_cnt = 0; rises = 0; bad_off = 0;
    vs_edges = 0; vs_bad = 0; pos = 0; line_idx = 0; first_line = -1;
    run_hs = 1; max_hs = 1; run_bl = 0; max_bl = 0;
    prev_hs = hs; prev_vs = vs; prev_bl = blank_n; found = 1'b0; n = 0;
`ifdef VTG_COORD_EN
    last_px = -1; last_py = -1;
`endif
    while (!found && n < 1000) begin
      tick();
      n++;
      if (line_start) begin
        ls_cnt++;
        pos = 0;
        line_idx = frame_start ? 0 : line_idx + 1;
      end else begin
        pos++;
      end
      if (!hs) begin hs_cnt++; run_hs++; end else run_hs = 0;
      if (run_hs > max_hs) max_hs = run_hs;
      if (!vs) vs_cnt++;
      if (vs != prev_vs) begin
        vs_edges++;
        if (!line_start) vs_bad++;
      end
      if (blank_n) begin bl_cnt++; run_bl++; end else run_bl = 0;
      if (run_bl > max_bl) max_bl = run_bl;
      if (blank_n && !prev_bl) begin
        rises++;
        if (pos != HSY + HBK) bad_off++;
        if (first_line < 0) begin
          first_line = line_idx;
`ifdef VTG_COORD_EN
          check("first_pix_x", int'(pix_x), 0);
          check("first_pix_y", int'(pix_y), 0);
`endif
        end
      end
`ifdef VTG_COORD_EN
      if (blank_n) begin last_px = int'(pix_x); last_py = int'(pix_y); end
`endif
      prev_hs = hs; prev_vs = vs; prev_bl = blank_n;
      found = frame_start;
    end
    check("frame_period", n, FRAME);
    check("line_starts_per_frame", ls_cnt, V_TOT);
    check("hs_active_cycles", hs_cnt, HSY * V_TOT);
    check("hs_max_run", max_hs, HSY);
    check("vs_active_cycles", vs_cnt, VSY * H_TOT);
    check("vs_edge_count", vs_edges, 2);
    check("vs_edge_not_on_line_start", vs_bad, 0);
    check("blank_cycles", bl_cnt, HAC * VAC);
    check("blank_max_run", max_bl, HAC);
    check("active_lines", rises, VAC);
    check("blank_rise_offset_errors", bad_off, 0);
    check("first_active_line", first_line, VSY + VBK);
`ifdef VTG_COORD_EN
    check("last_pix_x", last_px, HAC - 1);
    check("last_pix_y", last_py, VAC - 1);
`endif

    // Freeze mid-active line: line 6, pixel clock 10 of the line.
    advance(6 * H_TOT + 10);
    check("pre_freeze_visible", blank_n, 1);
    snap = {hs, vs, blank_n, line_start, frame_start};
    en = 1'b0;
    changes = 0;
    for (int i = 0; i < 37; i++) begin
      tick();
      if ({hs, vs, blank_n, line_start, frame_start} !== snap) changes++;
    end
    check("freeze_output_changes", changes, 0);
    en = 1'b1;
    wait_ls(n);
    check("resume_to_line_start", n, H_TOT - 10);
    wait_fs(n);
    check("resume_to_frame_start", n, FRAME - 7 * H_TOT);

    // Freeze on a pulse cycle: the pulses must not repeat.
    en = 1'b0;
    tick();
    check("frozen_line_start", line_start, 0);
    check("frozen_frame_start", frame_start, 0);
    tick();
    check("frozen_line_start_2", line_start, 0);
    en = 1'b1;
    wait_ls(n);
    check("pulse_freeze_line_len", n, H_TOT);

    // Asynchronous reset mid-frame (line 7, pixel 9), between clock edges.
    advance(6 * H_TOT + 9);
    check("pre_reset_visible", blank_n, 1);
    rst_n = 1'b0;
    #2;
    check("async_rst_hs", hs, 1);
    check("async_rst_vs", vs, 1);
    check("async_rst_blank", blank_n, 0);
    check("async_rst_line_start", line_start, 0);
    check("async_rst_frame_start", frame_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("restart_frame_start", frame_start, 1);
    check("restart_line_start", line_start, 1);
    check("restart_hs", hs, 0);
    check("restart_vs", vs, 0);
    wait_fs(n);
    check("restart_frame_period", n, FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Params SHALL be (name, default, meaning): H_SYNC 96 hsync px; H_BACK 48 h back porch px; H_ACTIVE 640 visible px; H_FRONT 16 h front porch px.
REQ-002 Params SHALL be: V_SYNC 2 vsync lines; V_BACK 33 v back porch lines; V_ACTIVE 480 visible lines; V_FRONT 10 v front porch lines.
REQ-003 Params SHALL be: HS_POL 0 active level of HS; VS_POL 0 active level of VS; CW 12 counter width (bits).
REQ-004 Port vga_clk  input  1  pixel clock; all state updates on rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port en  input  1  counter advance enable.
REQ-007 Ports HS, VS  output  1 each  registered syncs, polarity per HS_POL/VS_POL.
REQ-008 Port blank_n  output  1  registered; 1 inside visible area.
REQ-009 Ports line_start, frame_start  output  1 each  registered one-cycle pulses.
REQ-010 Ports pix_x, pix_y  output  CW each  registered visible coordinates (VTG_COORD_EN only).

Function
REQ-011 H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT and V_TOTAL = V_SYNC+V_BACK+V_ACTIVE+V_FRONT; each SHALL be < 2^CW, else elaboration SHALL fail.
REQ-012 h_cnt SHALL count 0..H_TOTAL-1 on each en=1 cycle, wrapping to 0; v_cnt SHALL increment only when h_cnt wraps, wrapping 0 after V_TOTAL-1.
REQ-013 Line order SHALL be sync, back porch, active, front porch, starting at h_cnt=0; frame order likewise from v_cnt=0.
REQ-014 HS SHALL equal HS_POL when h_cnt < H_SYNC, else ~HS_POL; VS SHALL equal VS_POL when v_cnt < V_SYNC, else ~VS_POL.
REQ-015 blank_n SHALL be 1 iff H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE and V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_ACTIVE.
REQ-016 line_start SHALL pulse when h_cnt=0; frame_start SHALL pulse when h_cnt=0 and v_cnt=0.
REQ-017 All outputs SHALL be registered with exactly 1 cycle latency from the counter state they decode; all outputs aligned to each other.
REQ-018 en=0 SHALL freeze counters and hold every output at its last value; line_start/frame_start SHALL NOT repeat while frozen (pulse only on the cycle counters advance into 0).
REQ-019 en re-asserted SHALL resume counting from the held position without skipping or repeating a count.
REQ-020 VS transitions SHALL coincide with the HS leading edge (both derived from h_cnt=0).

Reset
REQ-021 reset_n=0 SHALL asynchronously set h_cnt=0, v_cnt=0, HS=~HS_POL, VS=~VS_POL, blank_n=0, line_start=0, frame_start=0, pix_x=0, pix_y=0.
REQ-022 After reset_n deasserts with en=1, first rising edge SHALL register outputs decoded from h_cnt=0,v_cnt=0 (line_start=frame_start=1, HS/VS active).
REQ-023 Reset mid-frame SHALL abandon the frame; no partial-line state retained.

Configuration
REQ-024 Macro VTG_COORD_EN defined: pix_x = h_cnt-(H_SYNC+H_BACK), pix_y = v_cnt-(V_SYNC+V_BACK) while blank_n=1, 0 otherwise, same latency as blank_n.
REQ-025 VTG_COORD_EN undefined: pix_x/pix_y ports and their logic SHALL be absent.

Verification (defaults, en=1 unless stated)
REQ-026 Release reset -> frame_start pulse at first edge; next frame_start exactly 800*525=420000 cycles later; line_start every 800 cycles.
REQ-027 Per line -> HS low 96 cycles, blank_n high exactly 640 contiguous cycles beginning 144 cycles after HS falling edge.
REQ-028 Per frame -> VS low exactly 2 lines (1600 cycles), blank_n active on 480 lines starting at line 35; VS edges coincide with HS falling edge.
REQ-029 Drop en for 37 cycles mid-active line -> all outputs constant, no extra pulses; after resume, line still totals 800 enabled cycles.
REQ-030 VTG_COORD_EN, HS_POL=1,VS_POL=1 -> HS/VS high-active; first visible pixel pix_x=0,pix_y=0; last pix_x=639,pix_y=479; zero during blanking.
REQ-031 Assert reset_n=0 at h_cnt=500,v_cnt=200 -> outputs at reset values immediately (no clock); restart from frame_start.
